ram_bist_ctrl: RTL and testbench
================================

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 10, RAM address width.
REQ-002 SHALL have parameter WORD_SIZE, default 8, RAM data width.
REQ-003 SHALL have parameter MEM_SIZE, default 1024, number of words tested (addresses 0..MEM_SIZE-1).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin test; sampled only in IDLE or DONE.
REQ-007 SHALL have port addr  output  ADDR_SIZE  address driven to RAM.
REQ-008 SHALL have port data_in  output  WORD_SIZE  write data driven to RAM.
REQ-009 SHALL have port wr  output  1  RAM write strobe, level-sensitive at the RAM.
REQ-010 SHALL have port cs  output  1  RAM chip select.
REQ-011 SHALL have port data_out  input  WORD_SIZE  combinational RAM read data for current addr.
REQ-012 SHALL have port busy  output  1  high while test in progress.
REQ-013 SHALL have port done  output  1  high while in DONE.
REQ-014 SHALL have port pass  output  1  done and zero mismatches.
REQ-015 SHALL have port err_count  output  ADDR_SIZE+1  number of mismatching addresses.
REQ-016 SHALL have port fail_addr  output  ADDR_SIZE  first mismatching address; meaningful only when err_count != 0.

Function
REQ-017 SHALL implement FSM states IDLE, WR_SETUP, WR_STROBE, RD, DONE; all outputs registered.
REQ-018 SHALL define expected pattern for address k as (2*k) mod 2^WORD_SIZE.
REQ-019 SHALL, in IDLE or DONE with start=1, clear err_count, fail_addr and counter k=0, and enter WR_SETUP next cycle.
REQ-020 SHALL, in WR_SETUP, drive addr=k, data_in=pattern(k), cs=1, wr=0; next state WR_STROBE.
REQ-021 SHALL, in WR_STROBE, hold addr/data_in, drive cs=1, wr=1; then k=k+1 and WR_SETUP, or k=0 and RD after k=MEM_SIZE-1.
REQ-022 SHALL produce exactly one wr 0->1 transition per address, with addr and data_in stable one full cycle before and during wr=1 (the RAM writes only on wr/cs edges).
REQ-023 SHALL, in RD, drive addr=k, cs=1, wr=0, and at the clock edge ending the cycle compare data_out to pattern(k).
REQ-024 SHALL, on mismatch, increment err_count and, if err_count was 0, load fail_addr=k.
REQ-025 SHALL leave RD after k=MEM_SIZE-1 is compared and enter DONE; counter k wraps to 0 with no overflow.
REQ-026 SHALL make write phase 2*MEM_SIZE cycles, read phase MEM_SIZE cycles; done=1 in cycle 3*MEM_SIZE+1 after the edge sampling start (3073 at defaults).
REQ-027 SHALL assert busy=1 in WR_SETUP, WR_STROBE, RD; busy=0 in IDLE and DONE.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL hold done, pass, err_count, fail_addr stable in DONE until restart or reset.
REQ-030 SHALL drive cs=0, wr=0, addr=0, data_in=0 in IDLE and DONE.
REQ-031 SHALL set pass = done AND (err_count == 0); pass=0 whenever done=0.

Reset
REQ-032 SHALL, on rst=1 at any time including mid-test, immediately force state IDLE, k=0, addr=0, data_in=0, wr=0, cs=0, busy=0, done=0, pass=0, err_count=0, fail_addr=0.
REQ-033 SHALL, after rst deasserts, stay in IDLE until start=1 is sampled.

Verification
REQ-034 SHALL test: fault-free 1024x8 RAM model, start pulse -> done=1 at cycle 3073, pass=1, err_count=0; RAM word 7 holds 14, word 200 holds 144.
REQ-035 SHALL test: RAM model with data bit 0 stuck-at-1 at address 5 only -> err_count=1, fail_addr=5, pass=0.
REQ-036 SHALL test: RAM model ignoring writes to addresses 10 and 900 -> err_count=2, fail_addr=10.
REQ-037 SHALL test: rst=1 at cycle 100 of write phase -> same-cycle cs=0, wr=0, busy=0; later start -> full pass.
REQ-038 SHALL test: start re-pulsed while busy -> no effect, done still at cycle 3073; count wr rising edges = 1024 exactly.
REQ-039 SHALL test: restart from DONE after failing run with good RAM -> err_count cleared to 0, pass=1.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// ----------------------------------------------------------------------------
// ram_bist_ctrl
//   Built-in self test controller for a single-port RAM with a level-sensitive
//   write strobe. A start pulse runs one write pass that stores
//   pattern(k) = (2*k) mod 2^WORD_SIZE at every address 0..MEM_SIZE-1. A read
//   pass then compares every word against the same pattern. The controller
//   reports the number of mismatching addresses and the first failing one.
//
//   Each write takes two cycles: WR_SETUP presents addr/data with wr low, and
//   WR_STROBE raises wr. This gives exactly one wr rising edge per address,
//   with addr and data already stable for a full cycle before that edge.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin test (only sampled when not busy)
//   addr       out  RAM address
//   data_in    out  RAM write data
//   wr         out  RAM write strobe
//   cs         out  RAM chip select
//   data_out   in   combinational RAM read data for addr
//   busy       out  test in progress
//   done       out  test finished, results valid
//   pass       out  done with zero mismatches
//   err_count  out  number of mismatching addresses
//   fail_addr  out  first mismatching address (valid when err_count != 0)
// ----------------------------------------------------------------------------
module ram_bist_ctrl #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8,
    parameter int MEM_SIZE  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [ADDR_SIZE-1:0] addr,
    output logic [WORD_SIZE-1:0] data_in,
    output logic                 wr,
    output logic                 cs,
    input  logic [WORD_SIZE-1:0] data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_SIZE:0]   err_count,
    output logic [ADDR_SIZE-1:0] fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_RD,
        S_DONE
    } state_t;

    localparam logic [ADDR_SIZE-1:0] K_LAST = ADDR_SIZE'(MEM_SIZE - 1);

    // (2*k) mod 2^WORD_SIZE: shift left by one, then truncate or zero-extend.
    function automatic logic [WORD_SIZE-1:0] pattern(input logic [ADDR_SIZE-1:0] k);
        logic [ADDR_SIZE:0] dbl;
        dbl = {k, 1'b0};
        return WORD_SIZE'(dbl);
    endfunction

    state_t                 r_state, w_state_nxt;
    logic [ADDR_SIZE-1:0]   r_k, w_k_nxt;
    logic [ADDR_SIZE:0]     r_err, w_err_nxt;
    logic [ADDR_SIZE-1:0]   r_fail, w_fail_nxt;
    logic                   w_mismatch;

    logic [ADDR_SIZE-1:0]   r_addr, w_addr_nxt;
    logic [WORD_SIZE-1:0]   r_data, w_data_nxt;
    logic                   r_wr, w_wr_nxt;
    logic                   r_cs, w_cs_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_pass, w_pass_nxt;

    // In RD the RAM is addressed with r_k, so data_out belongs to word r_k.
    assign w_mismatch = (r_state == S_RD) && (data_out != pattern(r_k));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_err   <= '0;
            r_fail  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
            r_cs    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_wr    <= w_wr_nxt;
            r_cs    <= w_cs_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_WR_SETUP;
                    w_k_nxt     = '0;
                    w_err_nxt   = '0;
                    w_fail_nxt  = '0;
                end
            end
            S_WR_SETUP: w_state_nxt = S_WR_STROBE;
            S_WR_STROBE: begin
                if (r_k == K_LAST) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_RD;
                end else begin
                    w_k_nxt     = r_k + 1'b1;
                    w_state_nxt = S_WR_SETUP;
                end
            end
            S_RD: begin
                if (w_mismatch) begin
                    w_err_nxt = r_err + 1'b1;
                    if (r_err == '0) w_fail_nxt = r_k;
                end
                if (r_k == K_LAST) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and next counter, then
    // registered. This keeps every output a flop that is aligned with its state.
    always_comb begin
        w_addr_nxt = '0;
        w_data_nxt = '0;
        w_wr_nxt   = 1'b0;
        w_cs_nxt   = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        w_pass_nxt = 1'b0;

        case (w_state_nxt)
            S_WR_SETUP: begin
                w_addr_nxt = w_k_nxt;
                w_data_nxt = pattern(w_k_nxt);
                w_cs_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
            end
            S_WR_STROBE: begin
                w_addr_nxt = w_k_nxt;
                w_data_nxt = pattern(w_k_nxt);
                w_cs_nxt   = 1'b1;
                w_wr_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
            end
            S_RD: begin
                w_addr_nxt = w_k_nxt;
                w_cs_nxt   = 1'b1;
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
                w_pass_nxt = (w_err_nxt == '0);
            end
            default: ;
        endcase
    end

    assign addr      = r_addr;
    assign data_in   = r_data;
    assign wr        = r_wr;
    assign cs        = r_cs;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_addr = r_fail;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_bist_ctrl
//   Drives ram_bist_ctrl against a behavioural 1024x8 RAM with injectable
//   faults. Faults are ignored writes, whose words keep a preset non-pattern
//   value, and bit 0 stuck-at-1. The reference model tracks only "cycles since
//   start" and derives the expected bus and result values with arithmetic.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_bist_ctrl;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int N  = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          wr, cs, busy, done, pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] fail_addr;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .MEM_SIZE(N)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .data_in(data_in),
        .wr(wr), .cs(cs), .data_out(data_out), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_addr(fail_addr)
    );

    // ---------------- RAM model ----------------
    logic [DW-1:0] mem [N];
    logic [DW-1:0] pre [N];
    bit            ign [N];
    bit            stk [N];
    int            wr_rises = 0;

    always @(posedge wr) begin
        if (cs) begin
            wr_rises++;
            if (!ign[addr]) mem[addr] = data_in;
        end
    end

    assign data_out = (ign[addr] ? pre[addr] : mem[addr]) | {{(DW-1){1'b0}}, stk[addr]};

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] pat(int a);
        return DW'((2 * a) % (1 << DW));
    endfunction

    // ---------------- reference model ----------------
    int mcyc = 0;      // 0: not running; else the cycle number since start was sampled
    bit mdone = 0;
    int exp_tot, exp_first;
    int prefix [N+1];  // prefix[a] = number of bad words below address a

    function automatic void compute_expect();
        int v;
        exp_tot   = 0;
        exp_first = -1;
        for (int a = 0; a < N; a++) begin
            prefix[a] = exp_tot;
            v = ign[a] ? int'(pre[a]) : int'(pat(a));
            if (stk[a]) v = v | 1;
            if (v != int'(pat(a))) begin
                if (exp_first < 0) exp_first = a;
                exp_tot++;
            end
        end
        prefix[N] = exp_tot;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mcyc  = 0;
            mdone = 0;
        end else if (mcyc == 0) begin
            if (start) begin
                compute_expect();
                mcyc  = 1;
                mdone = 0;
            end
        end else if (mcyc == 3 * N) begin
            mcyc  = 0;
            mdone = 1;
        end else begin
            mcyc++;
        end
    end

    always @(negedge clk) begin : cmp_blk
        int            a;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ecs, ewr, eb, edn, eps;
        int            ee, ef;
        bit            chk_d, chk_f;
        ea = '0; ed = '0; ecs = 0; ewr = 0; eb = 0; edn = 0; eps = 0;
        ee = 0; ef = 0; chk_d = 1; chk_f = 0; a = 0;
        if (rst || (mcyc == 0 && !mdone)) begin
            // idle or in reset: everything zero
        end else if (mdone) begin
            edn   = 1;
            ee    = exp_tot;
            eps   = (exp_tot == 0);
            chk_f = (exp_tot != 0);
            ef    = exp_first;
        end else if (mcyc <= 2 * N) begin
            a   = (mcyc - 1) / 2;
            ea  = AW'(a);
            ed  = pat(a);
            ecs = 1;
            ewr = ((mcyc - 1) % 2) == 1;
            eb  = 1;
        end else begin
            a     = mcyc - 2 * N - 1;
            ea    = AW'(a);
            ecs   = 1;
            eb    = 1;
            chk_d = 0;
            ee    = prefix[a];
        end
        chk("cyc_addr", addr, ea);
        if (chk_d) chk("cyc_data_in", data_in, ed);
        chk("cyc_cs", cs, ecs);
        chk("cyc_wr", wr, ewr);
        chk("cyc_busy", busy, eb);
        chk("cyc_done", done, edn);
        chk("cyc_pass", pass, eps);
        chk("cyc_err_count", err_count, ee);
        if (chk_f) chk("cyc_fail_addr", fail_addr, ef);
    end

    // ---------------- stimulus ----------------
    task automatic run(input bit noisy, output int cyc);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 5000) begin
            @(posedge clk); #2;
            cyc++;
            start = (noisy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        chk("run_reached_done", done, 1);
        @(negedge clk);
        @(posedge clk); #2;
    endtask

    task automatic set_pre(input int a);
        ign[a] = 1;
        pre[a] = pat(a) ^ DW'($urandom_range(1, (1 << DW) - 1));
    endtask

    task automatic clear_faults();
        for (int a = 0; a < N; a++) begin
            ign[a] = 0;
            stk[a] = 0;
            pre[a] = DW'($urandom);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int r0, r1, r2;
        rst   = 1'b1;
        start = 1'b0;
        clear_faults();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_cs", cs, 0);
        chk("reset_err", err_count, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("idle_wait_busy", busy, 0);

        // fault-free run
        run(0, cyc);
        chk("good_done_cycle", cyc, 3073);
        chk("good_pass", pass, 1);
        chk("good_err", err_count, 0);
        chk("good_mem7", mem[7], 14);
        chk("good_mem200", mem[200], 144);

        // bit 0 stuck-at-1 at address 5
        stk[5] = 1;
        run(0, cyc);
        chk("stuck_err", err_count, 1);
        chk("stuck_fail_addr", fail_addr, 5);
        chk("stuck_pass", pass, 0);
        stk[5] = 0;

        // writes ignored at 10 and 900
        set_pre(10);
        set_pre(900);
        run(0, cyc);
        chk("ign_err", err_count, 2);
        chk("ign_fail_addr", fail_addr, 10);
        chk("ign_pass", pass, 0);

        // restart from DONE with a good RAM
        clear_faults();
        run(0, cyc);
        chk("restart_err", err_count, 0);
        chk("restart_pass", pass, 1);

        // reset during the write phase, cycle 100
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #2;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_cs", cs, 0);
        chk("midrst_wr", wr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #2;
        chk("post_rst_idle", busy, 0);
        run(0, cyc);
        chk("post_rst_cycle", cyc, 3073);
        chk("post_rst_pass", pass, 1);

        // start toggled randomly while busy
        wr_rises = 0;
        run(1, cyc);
        chk("noisy_done_cycle", cyc, 3073);
        chk("noisy_wr_rises", wr_rises, 1024);
        chk("noisy_pass", pass, 1);

        // random ignored-write faults
        r0 = $urandom_range(0, N - 1);
        r1 = $urandom_range(0, N - 1);
        r2 = $urandom_range(0, N - 1);
        set_pre(r0);
        set_pre(r1);
        set_pre(r2);
        run(1, cyc);
        chk("rand_err", err_count, exp_tot);
        chk("rand_fail_addr", fail_addr, exp_first);
        chk("rand_pass", pass, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
